// File: rtl/sync_fifo_16x8.sv
// sync_fifo_16x8: single-clock 16x8 byte FIFO, registered read data, status flags and occupancy count
module sync_fifo_16x8 #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   data_count,
    output logic              overflow,
    output logic              underflow
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr, rd_ptr, wr_next, rd_next, count_next;
    logic              wr_ok, rd_ok;

    // acceptance is judged on the registered (pre-edge) flags
    assign wr_ok      = wr_en && !full;
    assign rd_ok      = rd_en && !empty;
    assign wr_next    = wr_ptr + (ADDR_W+1)'(wr_ok);
    assign rd_next    = rd_ptr + (ADDR_W+1)'(rd_ok);
    assign count_next = wr_next - rd_next;

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[ADDR_W-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            dout       <= '0;
            valid      <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            wr_ptr     <= wr_next;
            rd_ptr     <= rd_next;
            data_count <= count_next;
            full       <= count_next == (ADDR_W+1)'(DEPTH);
            empty      <= count_next == '0;
            valid      <= rd_ok;
            overflow   <= wr_en && full;
            underflow  <= rd_en && empty;
            if (rd_ok) dout <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end
endmodule

// File: tb/tb_sync_fifo_16x8.sv
// tb_sync_fifo_16x8: directed self-checking bench for sync_fifo_16x8
module tb_sync_fifo_16x8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] dout;
    logic       valid, full, empty, overflow, underflow;
    logic [4:0] data_count;
    int         n_run = 0;
    int         n_fail = 0;

    sync_fifo_16x8 dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .valid(valid), .full(full), .empty(empty),
        .data_count(data_count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drive one cycle of inputs, then settle just past the edge
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] seq [5];
        seq[0] = 8'h12; seq[1] = 8'h34; seq[2] = 8'h34; seq[3] = 8'h56; seq[4] = 8'h78;
        #12 rst = 1'b0;
        cyc(0, 0, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", data_count, 0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);

        for (int i = 0; i < 5; i++) cyc(1, seq[i], 0);
        chk("w5_count", data_count, 5);
        chk("w5_empty", empty, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1);
            chk($sformatf("r5_dout%0d", i), dout, seq[i]);
            chk($sformatf("r5_valid%0d", i), valid, 1);
        end
        chk("r5_empty", empty, 1);
        chk("r5_count", data_count, 0);
        cyc(0, 0, 1);
        chk("unf_flag", underflow, 1);
        chk("unf_dout", dout, 8'h78);
        chk("unf_valid", valid, 0);
        cyc(0, 0, 0);
        chk("unf_clear", underflow, 0);

        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
        chk("fill_full", full, 1);
        chk("fill_count", data_count, 16);
        chk("fill_ovf0", overflow, 0);
        cyc(1, 8'hAA, 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", data_count, 16);
        cyc(0, 0, 0);
        chk("ovf_clear", overflow, 0);
        cyc(1, 8'hBB, 1);
        chk("fwr_dout", dout, 8'h00);
        chk("fwr_valid", valid, 1);
        chk("fwr_count", data_count, 15);
        chk("fwr_full", full, 0);
        chk("fwr_ovf", overflow, 1);
        for (int i = 1; i < 16; i++) begin
            cyc(0, 0, 1);
            chk($sformatf("drain_dout%0d", i), dout, 16'(i));
        end
        chk("drain_empty", empty, 1);

        cyc(1, 8'h80, 0);
        chk("one_count", data_count, 1);
        for (int i = 0; i < 40; i++) begin
            cyc(1, 8'(8'h81 + i), 1);
            chk($sformatf("wrap_dout%0d", i), dout, 16'(8'h80 + i));
            chk($sformatf("wrap_count%0d", i), data_count, 1);
        end
        cyc(0, 0, 1);
        chk("wrap_last", dout, 8'hA8);
        chk("wrap_empty", empty, 1);

        for (int i = 0; i < 7; i++) cyc(1, 8'(8'hC0 + i), 0);
        cyc(0, 0, 1);
        chk("pre_rst_count", data_count, 6);
        wr_en = 1'b0; rd_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_empty", empty, 1);
        chk("arst_count", data_count, 0);
        chk("arst_dout", dout, 8'h00);
        chk("arst_full", full, 0);
        @(negedge clk) rst = 1'b0;
        cyc(1, 8'h5A, 0);
        chk("post_count", data_count, 1);
        cyc(0, 0, 1);
        chk("post_dout", dout, 8'h5A);
        chk("post_valid", valid, 1);
        chk("post_empty", empty, 1);
        cyc(0, 0, 0);
        chk("post_valid0", valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
